// File: rtl/spm_ctrl_if.sv
// Bus-side handshake bundle for spm_ctrl: start/ready operand request and
// valid/ack product return.
interface spm_ctrl_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 ready;
    logic                 busy;
    logic [2*WIDTH-1:0]   prod;
    logic                 valid;
    logic                 ack;

    modport master (output start, a, b, ack, input ready, busy, prod, valid);
    modport slave  (input start, a, b, ack, output ready, busy, prod, valid);
endinterface

// File: rtl/spm_ctrl.sv
// Sequencer for the serial-parallel multiplier: clears the array, streams the
// multiplier LSB-first, and assembles the 2*WIDTH serial product.
// Optional macro SPM_CTRL_SIGNED_EN selects two's-complement operation.
module spm_ctrl #(
    parameter int WIDTH = 32,
    parameter int P_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    spm_ctrl_if.slave        bus,
    output logic [WIDTH-1:0] spm_x,
    output logic             spm_y,
    output logic             spm_clr,
    input  logic             spm_p
`ifdef SPM_CTRL_SIGNED_EN
    ,
    output logic             signed_mode
`endif
);
    localparam int PW      = 2 * WIDTH;
    localparam int RUN_LEN = PW + P_LAT;
    localparam int CW      = $clog2(RUN_LEN + 1);
    localparam logic [CW-1:0] LAST      = CW'(RUN_LEN - 1);
    localparam logic [CW-1:0] CAP_START = CW'(P_LAT);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  y_sreg;
    logic [PW-1:0]     p_sreg;
    logic [PW-1:0]     prod_q;
    logic              fill;

`ifdef SPM_CTRL_SIGNED_EN
    // Arithmetic shift keeps replicating b[WIDTH-1], sign-extending the stream.
    assign fill        = y_sreg[WIDTH-1];
    assign signed_mode = 1'b1;
`else
    assign fill = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = CLEAR;
            CLEAR:   state_nx = RUN;
            RUN:     if (cnt == LAST) state_nx = DONE;
            DONE:    if (bus.ack) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt    <= '0;
            y_sreg <= '0;
            p_sreg <= '0;
            prod_q <= '0;
            spm_x  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        spm_x  <= bus.a;
                        y_sreg <= bus.b;
                    end
                end
                CLEAR: cnt <= '0;
                RUN: begin
                    cnt    <= cnt + 1'b1;
                    y_sreg <= {fill, y_sreg[WIDTH-1:1]};
                    // The first P_LAT cycles only fill the SPM pipeline.
                    if (cnt >= CAP_START) p_sreg <= {spm_p, p_sreg[PW-1:1]};
                    if (cnt == LAST)      prod_q <= {spm_p, p_sreg[PW-1:1]};
                end
                default: ;
            endcase
        end
    end

    assign bus.ready = (state == IDLE);
    assign bus.busy  = (state == CLEAR) || (state == RUN);
    assign bus.valid = (state == DONE);
    assign bus.prod  = prod_q;
    assign spm_y     = (state == RUN) && y_sreg[0];
    // Held high through reset so the array is flushed regardless of state.
    assign spm_clr   = !rst || (state == IDLE) || (state == CLEAR);
endmodule
